// File: rtl/fp_pkg.sv
// fp_pkg: shared binary32 types, rounding/FSM enums, constants and special-operand classifier for fp_div_seq
package fp_pkg;
  typedef enum logic [2:0] {RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4} rmode_e;
  typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} div_state_e;
  typedef struct packed {
    logic        s;
    logic [7:0]  e;
    logic [22:0] f;
  } fp32_t;
  typedef struct packed {
    logic        hit;
    logic        dbz;
    logic [31:0] z;
  } fp_spec_t;
  localparam logic [9:0]  BIAS    = 10'd127;
  localparam logic [31:0] FP_QNAN = 32'h7FC00000;
  function automatic fp_spec_t div_special(input fp32_t x, input fp32_t y);
    fp_spec_t r;
    logic s, zx, zy, ix, iy, nan;
    s   = x.s ^ y.s;
    zx  = x.e == 8'h00;
    zy  = y.e == 8'h00;
    ix  = x.e == 8'hFF && x.f == 23'd0;
    iy  = y.e == 8'hFF && y.f == 23'd0;
    nan = (x.e == 8'hFF && x.f != 23'd0) || (y.e == 8'hFF && y.f != 23'd0) || (zx && zy) || (ix && iy);
    r.hit = nan | zx | zy | ix | iy;
    r.dbz = !nan && !ix && zy;
    r.z   = nan ? FP_QNAN : (ix || zy) ? {s, 8'hFF, 23'd0} : {s, 31'd0};
    return r;
  endfunction
endpackage

// File: rtl/fp_div_round.sv
// fp_div_round: combinational binary32 rounder (sign, mant[23:0], guard, sticky, r_mode -> frac[22:0], norm_r)
module fp_div_round
  import fp_pkg::*;
(
  input  logic        sign,
  input  logic [23:0] mant,
  input  logic        guard,
  input  logic        sticky,
  input  logic [2:0]  r_mode,
  output logic [22:0] frac,
  output logic        norm_r
);
  logic inc;
  logic [24:0] sum;
  always_comb begin
    inc = r_mode == RTZ ? 1'b0 :
          r_mode == RDN ? sign & (guard | sticky) :
          r_mode == RUP ? ~sign & (guard | sticky) :
          r_mode == RMM ? guard :
          guard & (sticky | mant[0]);
    sum = {1'b0, mant} + {24'd0, inc};
    norm_r = sum[24];
    frac = sum[23] ? sum[22:0] : 23'd0;
  end
endmodule

// File: rtl/fp_div_seq.sv
// fp_div_seq: sequential binary32 divider, restoring radix-2 (clk, rst_n, start, fp_X, fp_Y, r_mode -> busy, done, fp_Z, ovrf, udrf, dbz); FP_DIV_EARLY_EXC_EN finishes special operands in one cycle
module fp_div_seq
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] fp_X,
  input  logic [31:0] fp_Y,
  input  logic [2:0]  r_mode,
  output logic        busy,
  output logic        done,
  output logic [31:0] fp_Z,
  output logic        ovrf,
  output logic        udrf,
  output logic        dbz
);
  div_state_e state, nxt;
  fp32_t x, y;
  fp_spec_t sin, spr, src;
  logic sgn, ge, early, ld, g, st, nr, of, uf;
  logic [7:0] ex, ey;
  logic [23:0] dvs, d, mant;
  logic [24:0] rem;
  logic [26:0] q;
  logic [4:0] cnt;
  logic [2:0] rm;
  logic [22:0] frac;
  logic [9:0] e;
  logic [31:0] z_n;
  assign x = fp_X;
  assign y = fp_Y;
  assign sin = div_special(x, y);
`ifdef FP_DIV_EARLY_EXC_EN
  assign early = sin.hit;
  assign src = state == IDLE ? sin : spr;
`else
  assign early = 1'b0;
  assign src = spr;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = state == IDLE  ? (start ? (early ? DONE : DIV) : IDLE) :
          state == DIV   ? (cnt == 5'd0 ? ROUND : DIV) :
          state == ROUND ? DONE : IDLE;
  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
  end
  always_comb begin
    ge = rem >= {1'b0, dvs};
    d = ge ? 24'(rem - {1'b0, dvs}) : rem[23:0];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sgn <= 1'b0;
      ex  <= 8'd0;
      ey  <= 8'd0;
      dvs <= 24'd0;
      rem <= 25'd0;
      q   <= 27'd0;
      cnt <= 5'd0;
      rm  <= 3'd0;
      spr <= '0;
    end else if (state == IDLE && start) begin
      sgn <= x.s ^ y.s;
      ex  <= x.e;
      ey  <= y.e;
      dvs <= {1'b1, y.f};
      rem <= {2'b01, x.f};
      q   <= 27'd0;
      cnt <= 5'd26;
      rm  <= r_mode;
      spr <= sin;
    end else if (state == DIV) begin
      q   <= {q[25:0], ge};
      rem <= {d, 1'b0};
      cnt <= cnt - 5'd1;
    end
  always_comb begin
    mant = q[26] ? q[26:3] : q[25:2];
    g = q[26] ? q[2] : q[1];
    st = (q[26] ? |q[1:0] : q[0]) | (|rem);
  end
  fp_div_round u_round (
    .sign  (sgn),
    .mant  (mant),
    .guard (g),
    .sticky(st),
    .r_mode(rm),
    .frac  (frac),
    .norm_r(nr)
  );
  always_comb begin
    e = {2'b00, ex} - {2'b00, ey} + BIAS - {9'd0, ~q[26]} + {9'd0, nr};
    of = ~e[9] & (e >= 10'd255);
    uf = e[9] | (e == 10'd0);
    z_n = src.hit ? src.z : of ? {sgn, 8'hFF, 23'd0} : uf ? {sgn, 31'd0} : {sgn, e[7:0], frac};
    ld = nxt == DONE && state != DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fp_Z <= 32'd0;
      ovrf <= 1'b0;
      udrf <= 1'b0;
      dbz  <= 1'b0;
    end else if (ld) begin
      fp_Z <= z_n;
      ovrf <= ~src.hit & of;
      udrf <= ~src.hit & ~of & uf;
      dbz  <= src.hit & src.dbz;
    end
endmodule

// File: tb/tb_fp_div_seq.sv
// tb_fp_div_seq: directed scoreboard bench for fp_div_seq (latency, rounding modes, specials, flags, reset abort, start ignore)
module tb_fp_div_seq;
  logic clk, rst_n, start, busy, done, ovrf, udrf, dbz;
  logic [31:0] fp_X, fp_Y, fp_Z;
  logic [2:0] r_mode;
  int checks = 0, fails = 0;
  typedef struct {
    logic [31:0] z;
    logic [2:0]  fl;
    int          lat;
  } exp_t;
  exp_t sb[$];
  fp_div_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .fp_X(fp_X), .fp_Y(fp_Y), .r_mode(r_mode),
    .busy(busy), .done(done), .fp_Z(fp_Z), .ovrf(ovrf), .udrf(udrf), .dbz(dbz)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic op(input string tag, input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm,
                    input logic [31:0] z, input logic [2:0] fl, input bit sp, input bit mid);
    exp_t ex;
    int n, bb;
    ex.z = z;
    ex.fl = fl;
    ex.lat = 29;
`ifdef FP_DIV_EARLY_EXC_EN
    if (sp) ex.lat = 1;
`endif
    sb.push_back(ex);
    fp_X = x;
    fp_Y = y;
    r_mode = rm;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    bb = 0;
    while (!done && n < 40) begin
      if (!busy) bb++;
      @(negedge clk);
      n++;
      if (n == 2) begin
        fp_X = $urandom;
        fp_Y = $urandom;
        r_mode = 3'($urandom);
      end
      if (mid && n == 5) begin
        fp_X = 32'h3F800000;
        fp_Y = 32'h40400000;
      end
      start = mid && n == 5;
    end
    start = 1'b0;
    ex = sb.pop_front();
    chk({tag, "/done"}, {31'd0, done}, 32'd1);
    chk({tag, "/latency"}, 32'(n), 32'(ex.lat));
    chk({tag, "/busy_run"}, 32'(bb), 32'd0);
    chk({tag, "/busy_done"}, {31'd0, busy}, 32'd1);
    chk({tag, "/fp_Z"}, fp_Z, ex.z);
    chk({tag, "/flags"}, {29'd0, ovrf, udrf, dbz}, {29'd0, ex.fl});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "/done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, "/idle"}, {31'd0, busy}, 32'd0);
    chk({tag, "/hold"}, fp_Z, ex.z);
  endtask
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    fp_X = 32'd0;
    fp_Y = 32'd0;
    r_mode = 3'd0;
    repeat (2) @(negedge clk);
    chk("rst/busy", {31'd0, busy}, 32'd0);
    chk("rst/done", {31'd0, done}, 32'd0);
    chk("rst/fp_Z", fp_Z, 32'd0);
    chk("rst/flags", {29'd0, ovrf, udrf, dbz}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    op("6div2",      32'h40C00000, 32'h40000000, 3'd0, 32'h40400000, 3'b000, 1'b0, 1'b1);
    op("1div3_rne",  32'h3F800000, 32'h40400000, 3'd0, 32'h3EAAAAAB, 3'b000, 1'b0, 1'b0);
    op("1div3_rtz",  32'h3F800000, 32'h40400000, 3'd1, 32'h3EAAAAAA, 3'b000, 1'b0, 1'b0);
    op("1div3_rdn",  32'h3F800000, 32'h40400000, 3'd2, 32'h3EAAAAAA, 3'b000, 1'b0, 1'b0);
    op("1div3_rup",  32'h3F800000, 32'h40400000, 3'd3, 32'h3EAAAAAB, 3'b000, 1'b0, 1'b0);
    op("1div3_rmm",  32'h3F800000, 32'h40400000, 3'd4, 32'h3EAAAAAB, 3'b000, 1'b0, 1'b0);
    op("1div3_m7",   32'h3F800000, 32'h40400000, 3'd7, 32'h3EAAAAAB, 3'b000, 1'b0, 1'b0);
    op("n1div3_rdn", 32'hBF800000, 32'h40400000, 3'd2, 32'hBEAAAAAB, 3'b000, 1'b0, 1'b0);
    op("n1div3_rup", 32'hBF800000, 32'h40400000, 3'd3, 32'hBEAAAAAA, 3'b000, 1'b0, 1'b0);
    op("n6div2",     32'hC0C00000, 32'h40000000, 3'd0, 32'hC0400000, 3'b000, 1'b0, 1'b0);
    op("maxdiv1",    32'h7F7FFFFF, 32'h3F800000, 3'd0, 32'h7F7FFFFF, 3'b000, 1'b0, 1'b0);
    op("mindiv1",    32'h00800000, 32'h3F800000, 3'd0, 32'h00800000, 3'b000, 1'b0, 1'b0);
    op("1div0",      32'h3F800000, 32'h00000000, 3'd0, 32'h7F800000, 3'b001, 1'b1, 1'b0);
    op("n1div0",     32'hBF800000, 32'h00000000, 3'd0, 32'hFF800000, 3'b001, 1'b1, 1'b0);
    op("0div0",      32'h00000000, 32'h00000000, 3'd0, 32'h7FC00000, 3'b000, 1'b1, 1'b0);
    op("nan_in",     32'h7FC00001, 32'h3F800000, 3'd0, 32'h7FC00000, 3'b000, 1'b1, 1'b0);
    op("infdiv2",    32'h7F800000, 32'h40000000, 3'd0, 32'h7F800000, 3'b000, 1'b1, 1'b0);
    op("2divinf",    32'h40000000, 32'h7F800000, 3'd0, 32'h00000000, 3'b000, 1'b1, 1'b0);
    op("n0div2",     32'h80000000, 32'h40000000, 3'd0, 32'h80000000, 3'b000, 1'b1, 1'b0);
    op("subnorm",    32'h00000001, 32'h3F800000, 3'd0, 32'h00000000, 3'b000, 1'b1, 1'b0);
    op("ovf_rne",    32'h7F000000, 32'h00800000, 3'd0, 32'h7F800000, 3'b100, 1'b0, 1'b0);
    op("ovf_rtz",    32'h7F000000, 32'h00800000, 3'd1, 32'h7F800000, 3'b100, 1'b0, 1'b0);
    op("udf",        32'h00800000, 32'h7F000000, 3'd0, 32'h00000000, 3'b010, 1'b0, 1'b0);
    op("pre_rst",    32'h40C00000, 32'h40000000, 3'd0, 32'h40400000, 3'b000, 1'b0, 1'b0);
    fp_X = 32'h3F800000;
    fp_Y = 32'h00000000;
    r_mode = 3'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort/busy", {31'd0, busy}, 32'd0);
    chk("abort/done", {31'd0, done}, 32'd0);
    chk("abort/fp_Z", fp_Z, 32'd0);
    chk("abort/flags", {29'd0, ovrf, udrf, dbz}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort/idle", {31'd0, busy}, 32'd0);
    op("post_rst",   32'h3F800000, 32'h40400000, 3'd1, 32'h3EAAAAAA, 3'b000, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/fp_div_seq.md
# fp_div_seq

Sequential IEEE-754 single-precision divider, the inverse operation of the combinational `fp_mul` unit in the FPU. It computes fp_Z = fp_X / fp_Y with a radix-2 restoring mantissa iteration. It uses the same rounding-mode encoding, flush-to-zero subnormal policy and ovrf/udrf flag semantics as the multiplier. It sits beside the multiplier in the ALU and talks to the issue logic through a start/busy/done handshake.

## Interface
- No parameters; all widths are fixed by binary32.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request a division; only sampled while `busy`=0.
- `fp_X` input 32: dividend; captured when `start` is accepted.
- `fp_Y` input 32: divisor; captured when `start` is accepted.
- `r_mode` input 3: rounding mode, captured with the operands.
  - 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM.
  - 101–111 behave as RNE.
- `busy` output 1: high from the cycle after accept until `done` drops.
- `done` output 1: single-cycle pulse; `fp_Z` and the flags are valid in this cycle.
- `fp_Z` output 32: quotient; holds its value until the next `done`.
- `ovrf` output 1: overflow flag, updated with `fp_Z`.
- `udrf` output 1: underflow flag, updated with `fp_Z`.
- `dbz` output 1: divide-by-zero flag (finite nonzero / zero), updated with `fp_Z`.

## Operation
- **FSM states:** IDLE, DIV, ROUND, DONE.
  - IDLE → DIV when `start`=1.
  - DIV → ROUND after 27 iterations (5-bit down-counter, 26 → 0).
  - ROUND → DONE.
  - DONE → IDLE; a `start` arriving in DONE is ignored.
- **Operand classes:**
  - Exponent 0 means zero; subnormal inputs are flushed to zero.
  - Exponent FF with fraction 0 is inf; exponent FF with fraction ≠0 is NaN.
- **Special results** (sign = X[31]^Y[31] unless NaN):
  - NaN in, 0/0 or inf/inf → 32'h7FC00000.
  - inf/finite → signed inf.
  - finite nonzero/0 → signed inf with `dbz`=1.
  - 0/nonzero → signed zero.
  - finite/inf → signed zero.
- **Mantissa divide:**
  - Dividend {1,frc_X}, divisor {1,frc_Y}; the partial remainder is 25 bits.
  - Each DIV cycle produces one quotient bit into q[26:0], MSB first; q[26] is the integer bit.
- **Normalize:**
  - If q[26]=1: mantissa = q[26:3], guard = q[2], sticky = |q[1:0] | (rem≠0).
  - If q[26]=0: mantissa = q[25:2], guard = q[1], sticky = q[0] | (rem≠0), and the exponent is decremented by 1.
- **Rounding** uses the same rules as the multiplier:
  - RNE rounds up on guard & (sticky | lsb).
  - RTZ truncates.
  - RDN increments when sign=1 and (guard|sticky).
  - RUP increments when sign=0 and (guard|sticky).
  - RMM increments on guard.
  - A fraction carry-out (norm_r) zeroes the fraction and increments the exponent.
- **Exponent:**
  - 10-bit signed: e = eX − eY + 127 − (q[26]?0:1) + norm_r.
  - e ≥ 255 → `ovrf`=1, result = signed inf (all rounding modes).
  - e ≤ 0 → `udrf`=1, result = signed zero.
- **Flags:** each result clears every flag it does not set.

## Timing
- **Reset values:** all outputs 0; state IDLE.
- **Reset mid-operation:** abort the operation; return to IDLE; drive all outputs to 0.
- **Latency:** `start` sampled in cycle 0; DIV occupies cycles 1–27, ROUND cycle 28, `done`=1 in cycle 29.
- **Throughput:** one operation per 30 cycles; the earliest accepted `start` is in cycle 30.
- **Input stability:** inputs are registered at accept, so later changes to `fp_X`, `fp_Y` and `r_mode` have no effect.

## Configuration
- **`FP_DIV_EARLY_EXC_EN` defined:** special-class operands skip DIV and ROUND.
  - The FSM goes IDLE → DONE, with `done` in cycle 1.
- **`FP_DIV_EARLY_EXC_EN` undefined:** special operands still traverse all states; the result is overridden in ROUND.
  - Latency is always 29 cycles.

## Structure
- **`fp_pkg`** holds the shared definitions:
  - `rmode_e` enum.
  - `BIAS`=127 and `FP_QNAN`=32'h7FC00000.
  - binary32 field typedef.
  - `div_state_e` enum.
- **`fp_div_round`** is the one sub-module: a combinational rounder.
  - Inputs: sign, 24-bit mantissa, guard, sticky, r_mode.
  - Outputs: 23-bit fraction and norm_r.
  - Written so the multiplier can reuse it.

## Test plan
- 6.0/2.0: 0x40C00000 / 0x40000000, RNE → `fp_Z`=0x40400000 with `done` in cycle 29 only; `busy` high in cycles 1–29.
- 1.0/3.0: 0x3F800000 / 0x40400000 → RNE gives 0x3EAAAAAB, RTZ gives 0x3EAAAAAA, RUP gives 0x3EAAAAAB.
- Divide by zero: 0x3F800000 / 0x00000000 → 0x7F800000 with `dbz`=1; 0xBF800000 / 0x00000000 → 0xFF800000; 0/0 → 0x7FC00000 with `dbz`=0.
- Overflow and underflow:
  - 0x7F000000 / 0x00800000 → 0x7F800000 with `ovrf`=1.
  - 0x00800000 / 0x7F000000 → 0x00000000 with `udrf`=1.
- Reset and busy: `rst_n` low in cycle 10 → `busy`, `done` and `fp_Z` all 0 immediately; a `start` issued in cycle 5 of an operation is ignored.
- Build configuration, 0/0:
  - With `FP_DIV_EARLY_EXC_EN`: 0x7FC00000 with `done` in cycle 1.
  - Without it: the same result in cycle 29.
